fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO between `NUM_REQ` producers. It selects one pending requester, drives the FIFO `wr_en`/`data_in` for one cycle, then checks the FIFO's registered `wr_ack`. On a refused write it retries a bounded number of times, and past that bound it drops the word. It sits directly in front of the FIFO write interface; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one synchronous-FIFO write port between
//   NUM_REQ producers. A granted word is captured, written for one cycle,
//   then confirmed against the FIFO's registered wr_ack. Refused writes are
//   retried (requester locked) up to MAX_RETRY attempts, then dropped.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/req_data: per-requester request and word (word i at [i*W +: W])
//   req_ack/req_drop  : one-cycle one-hot accept / discard pulses
//   fifo_wr_en/fifo_data_in : FIFO write strobe and data
//   fifo_full/fifo_wr_ack   : FIFO full flag and registered write acknowledge
//   grant_id, busy, write_count : current owner, activity, accepted-write count
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_drop,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   write_count
);

  localparam int GW = $clog2(NUM_REQ);
  typedef logic [GW-1:0] id_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t                 state;
  id_t                    rr_ptr;
  logic [3:0]             retry_cnt;
  logic [3:0]             retry_next;
  logic                   lock;
  logic [FIFO_WIDTH-1:0]  hold_data;

  id_t                    arb_start;
  logic [NUM_REQ-1:0]     cand;
  int                     pos;
  logic                   win_found;
  id_t                    win_id;
  logic [FIFO_WIDTH-1:0]  win_data;
  logic                   launch;
  logic                   check_ack;
  logic                   check_drop;

  // Successor of a requester index, wrapping at NUM_REQ (which need not be a power of two).
  function automatic id_t next_id(input id_t id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Round-robin search. In CHECK the search already reflects the pointer
  // advance of an ack and excludes the requester just served, so a
  // back-to-back grant never goes to the same requester twice in a row.
  always_comb begin
    arb_start = rr_ptr;
    cand      = req_valid;
    if (state == CHECK) begin
      arb_start      = next_id(grant_id);
      cand[grant_id] = 1'b0;
    end
    pos       = 0;
    win_found = 1'b0;
    win_id    = arb_start;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(arb_start) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!win_found && cand[id_t'(pos)]) begin
        win_found = 1'b1;
        win_id    = id_t'(pos);
      end
    end
    // A refused word keeps the port: the same requester is reissued.
    if (state == IDLE && lock) begin
      win_found = 1'b1;
      win_id    = grant_id;
    end
    win_data = req_data[int'(win_id)*FIFO_WIDTH +: FIFO_WIDTH];
    launch   = win_found && !fifo_full;
  end

  // Ack/drop pulses are combinational in CHECK; reset suppresses them.
  always_comb begin
    retry_next = retry_cnt + 4'd1;
    check_ack  = (state == CHECK) && fifo_wr_ack && !rst;
    check_drop = (state == CHECK) && !fifo_wr_ack && (retry_next == 4'(MAX_RETRY)) && !rst;
    req_ack    = '0;
    req_drop   = '0;
    if (check_ack)  req_ack[grant_id]  = 1'b1;
    if (check_drop) req_drop[grant_id] = 1'b1;
  end

  assign fifo_data_in = hold_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      retry_cnt   <= '0;
      lock        <= 1'b0;
      grant_id    <= '0;
      hold_data   <= '0;
      fifo_wr_en  <= 1'b0;
      busy        <= 1'b0;
      write_count <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            grant_id   <= win_id;
            // Locked retries resend the originally captured word.
            if (!lock) hold_data <= win_data;
            fifo_wr_en <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (fifo_wr_ack) begin
            write_count <= write_count + 16'd1;
            rr_ptr      <= next_id(grant_id);
            retry_cnt   <= '0;
            lock        <= 1'b0;
            if (launch) begin
              grant_id   <= win_id;
              hold_data  <= win_data;
              fifo_wr_en <= 1'b1;
              state      <= ISSUE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (retry_next == 4'(MAX_RETRY)) begin
            rr_ptr    <= next_id(grant_id);
            retry_cnt <= '0;
            lock      <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            retry_cnt <= retry_next;
            lock      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios with literal expectations
// plus a transaction-level model of the write port checked every cycle.
module tb_fifo_wr_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [W-1:0]  words [N];
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ack, req_drop;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data_in;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_ack = 1'b0;
  logic [1:0]    grant_id;
  logic          busy;
  logic [15:0]   write_count;
  logic          refuse = 1'b0;

  always #5 clk = ~clk;

  assign req_data = {words[3], words[2], words[1], words[0]};

  // Registered FIFO acknowledge: answers a write one cycle later.
  always @(posedge clk) fifo_wr_ack <= fifo_wr_en && !refuse;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .req_drop(req_drop), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack),
    .grant_id(grant_id), .busy(busy), .write_count(write_count));

  int n_checks = 0;
  int n_err    = 0;

  // Model state: round-robin pointer, accepted count, refusal count, lock.
  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;
  int          m_ref = 0;
  logic        m_lock = 1'b0;
  int          m_gnt = 0;
  logic [W-1:0] m_data = '0;
  // Values seen in previous cycles.
  logic [N-1:0] p_valid = '0, p_done = '0;
  logic         p_full = 1'b0, p_wr = 1'b0, p2_wr = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
  logic [W-1:0] p_words [N];
  logic         auto_clear = 1'b1;
  logic [N-1:0] done_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [N-1:0] cand, exp_ack, exp_drop;
    int win;
    logic exp_wr;
    cand = p_valid & ~p_done;
    win  = -1;
    if (m_lock) win = m_gnt;
    else
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (win < 0 && cand[i]) win = i;
      end
    // The port can start a write if it was idle last cycle, or last cycle was an accepted check.
    exp_wr = !p_rst && !p_wr && (!p2_wr || p_ack) && (win >= 0) && !p_full;
    chk("wr_en", fifo_wr_en, exp_wr);
    chk("busy", busy, fifo_wr_en || p_wr);
    exp_ack  = '0;
    exp_drop = '0;
    if (rst) begin
      chk("ack_in_rst", req_ack, '0);
      chk("drop_in_rst", req_drop, '0);
      m_ptr = 0; m_cnt = '0; m_ref = 0; m_lock = 1'b0;
    end else begin
      if (p_wr) begin
        if (fifo_wr_ack) exp_ack[m_gnt] = 1'b1;
        else if (m_ref + 1 == 3) exp_drop[m_gnt] = 1'b1;
      end
      chk("ack", req_ack, exp_ack);
      chk("drop", req_drop, exp_drop);
      chk("write_count", write_count, m_cnt);
      if (exp_ack != 0) begin
        m_cnt = m_cnt + 16'd1; m_ptr = (m_gnt + 1) % N; m_ref = 0; m_lock = 1'b0;
      end else if (p_wr) begin
        m_ref++;
        if (m_ref == 3) begin
          m_ptr = (m_gnt + 1) % N; m_ref = 0; m_lock = 1'b0;
        end else m_lock = 1'b1;
      end
      if (fifo_wr_en && exp_wr) begin
        if (!m_lock) m_data = p_words[win];
        m_gnt = win;
        chk("grant", grant_id, m_gnt);
        chk("data", fifo_data_in, m_data);
      end
    end
    p2_wr   = p_wr;
    p_wr    = rst ? 1'b0 : fifo_wr_en;
    p_ack   = (exp_ack != 0);
    p_done  = exp_ack | exp_drop;
    p_valid = req_valid;
    p_full  = fifo_full;
    p_words = words;
    p_rst   = rst;
    done_mask = auto_clear ? (exp_ack | exp_drop) : '0;
  endtask

  // One clock: model check at the falling edge, then inputs settle 1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~done_mask;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin words[i] = '0; p_words[i] = '0; end
    rst = 1'b1;
    tick(); tick();
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", write_count, 0);
    rst = 1'b0;

    // Single requester: wr_en one cycle after the grant, ack the cycle after.
    words[2] = 16'hA5A5; req_valid = 4'b0100;
    tick();
    chk("t1_wr_en", fifo_wr_en, 1);
    chk("t1_data", fifo_data_in, 16'hA5A5);
    chk("t1_grant", grant_id, 2);
    tick();
    chk("t1_ack", req_ack, 4'b0100);
    tick();
    chk("t1_count", write_count, 1);
    chk("t1_ack_gone", req_ack, 0);
    tick();

    // All requesters continuously valid: strict rotation, one write every two cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    auto_clear = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_wr_en", fifo_wr_en, 1);
      chk("t2_grant", grant_id, k % 4);
      chk("t2_data", fifo_data_in, words[k % 4]);
      tick();
      chk("t2_gap", fifo_wr_en, 0);
      chk("t2_ack", req_ack, 4'b0001 << (k % 4));
    end
    req_valid = '0; auto_clear = 1'b1;
    repeat (4) tick();

    // FIFO full holds the arbiter idle; release issues on the next cycle.
    fifo_full = 1'b1; words[1] = 16'hBEEF; req_valid = 4'b0010;
    repeat (4) begin
      tick();
      chk("t3_wr_blocked", fifo_wr_en, 0);
      chk("t3_busy", busy, 0);
    end
    fifo_full = 1'b0;
    tick();
    chk("t3_wr_en", fifo_wr_en, 1);
    chk("t3_grant", grant_id, 1);
    chk("t3_data", fifo_data_in, 16'hBEEF);
    tick();
    chk("t3_ack", req_ack, 4'b0010);
    tick();

    // Three refusals: same word resent each time (even if source changes), then dropped.
    refuse = 1'b1; words[0] = 16'h1234; words[1] = 16'h5678; req_valid = 4'b0011;
    for (int a = 0; a < 3; a++) begin
      tick();
      chk("t4_wr_en", fifo_wr_en, 1);
      chk("t4_grant", grant_id, 0);
      chk("t4_data", fifo_data_in, 16'h1234);
      if (a == 0) words[0] = 16'hFFFF;
      tick();
      chk("t4_drop", req_drop, (a == 2) ? 4'b0001 : 4'b0000);
      chk("t4_no_ack", req_ack, 0);
      if (a < 2) begin
        tick();
        chk("t4_idle", fifo_wr_en, 0);
      end
    end
    refuse = 1'b0;
    tick();
    chk("t4_after_drop", fifo_wr_en, 0);
    tick();
    chk("t4_next_grant", grant_id, 1);
    chk("t4_next_data", fifo_data_in, 16'h5678);
    tick();
    chk("t4_next_ack", req_ack, 4'b0010);
    tick();

    // Reset during CHECK suppresses the ack and restarts arbitration at requester 0.
    words[2] = 16'hC3C3; words[0] = 16'h0F0F; req_valid = 4'b0100;
    tick();
    chk("t5_grant", grant_id, 2);
    tick();
    rst = 1'b1; req_valid = 4'b0101;
    #1;
    chk("t5_ack_suppressed", req_ack, 0);
    chk("t5_drop_suppressed", req_drop, 0);
    tick();
    chk("t5_wr_en", fifo_wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant_rst", grant_id, 0);
    chk("t5_count", write_count, 0);
    chk("t5_data_rst", fifo_data_in, 0);
    rst = 1'b0;
    tick();
    chk("t5_regrant", grant_id, 0);
    chk("t5_regrant_data", fifo_data_in, 16'h0F0F);
    tick();
    chk("t5_reack", req_ack, 4'b0001);
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
